// File: rtl/ceespu_pkg.sv
// ceespu shared constants: data-memory controller state encoding,
// SRAM half selectors and the read write-enable pattern.
package ceespu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/ceespu_dmem_ctrl.sv
// ceespu data-memory controller: one 32-bit core access split into two
// 16-bit async SRAM phases (low half first), WAIT extra cycles per phase.
// Ports: clk/rst (sync, active-high); core side dmem_e/we/addr/wdata in,
// dmem_rdata/dmem_busy out; SRAM side sram_addr/wdata/ce/we/be out,
// sram_rdata in. Only dmem_busy depends combinationally on an input.
module ceespu_dmem_ctrl
    import ceespu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_e,
    input  logic [3:0]        dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_busy,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [1:0]        sram_be
);

    localparam logic [3:0] WAIT4 = 4'(WAIT);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-3:0] word;
    logic [3:0]        we;
    logic [31:0]       wdata;
    logic [15:0]       rdLo;
    logic              isRead;
    logic              isHi;
    logic              unusedAddrBits;

    assign unusedAddrBits = ^dmem_addr[1:0];

    assign isRead = (we == WE_READ);
    assign isHi   = (state == HI);

    assign dmem_busy = (state != IDLE) | dmem_e;

    // SRAM pins are decoded from registered state only.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = 2'b00;
        sram_wdata = 16'h0000;
        if (state == LO || state == HI) begin
            sram_ce    = 1'b1;
            sram_we    = !isRead;
            sram_addr  = {word, isHi ? HALF_HI : HALF_LO};
            sram_be    = isRead ? 2'b11 : (isHi ? we[3:2] : we[1:0]);
            sram_wdata = isHi ? wdata[31:16] : wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            word       <= '0;
            we         <= WE_READ;
            wdata      <= 32'h0;
            rdLo       <= 16'h0;
            dmem_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_e) begin
                        word  <= dmem_addr[ADDR_W-1:2];
                        we    <= dmem_we;
                        wdata <= dmem_wdata;
                        cnt   <= WAIT4;
                        // Upper-half-only stores skip the low phase.
                        if (dmem_we != WE_READ && dmem_we[1:0] == 2'b00)
                            state <= HI;
                        else
                            state <= LO;
                    end
                end
                LO: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (isRead)
                            rdLo <= sram_rdata;
                        cnt <= WAIT4;
                        if (!isRead && we[3:2] == 2'b00)
                            state <= IDLE;
                        else
                            state <= HI;
                    end
                end
                HI: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Both halves land together so the core never
                        // sees a half-updated word.
                        if (isRead)
                            dmem_rdata <= {sram_rdata, rdLo};
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
